// File: rtl/spi_slave_core.sv
`timescale 1ns/1ps
// SPI slave core: pins are synchronized into the clock domain, bytes are shifted MSB first.
// Define SPI_SLAVE_RX_FIFO_EN for a 4-entry receive FIFO; otherwise a single holding register.
module spi_slave_core #(
    parameter int PHASE  = 0,
    parameter int ACTIVE = 0
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       rx_ovr,
    output logic [7:0] byte_cnt
);

    localparam int   DATA_W   = 8;
    localparam logic SCK_IDLE = (ACTIVE != 0);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic cs_n_p0, cs_n_p1, cs_n_p2;
    logic sck_p0, sck_p1, sck_p2;
    logic mosi_p0, mosi_p1;
    logic [1:0] flush_q;
    logic cs_arm_q;

    state_t state_q, state_d;
    logic [2:0] bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_sr, tx_word;
    logic push_vld_p0, miso_q, load_en;
    logic lead_stb, trail_stb, active, sample_stb, shift_stb, cs_fall;
    logic push, pop, full, accept;

    // Stages p0/p1: two-flop synchronizers; p2: history for edge detection
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            cs_n_p0 <= 1'b1;
            cs_n_p1 <= 1'b1;
            cs_n_p2 <= 1'b1;
            sck_p0  <= SCK_IDLE;
            sck_p1  <= SCK_IDLE;
            sck_p2  <= SCK_IDLE;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            cs_n_p0 <= cs_n;
            cs_n_p1 <= cs_n_p0;
            cs_n_p2 <= cs_n_p1;
            sck_p0  <= sck;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    // A falling edge only counts once cs_n has really been seen high after the reset values flush out.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            flush_q  <= 2'd0;
            cs_arm_q <= 1'b0;
        end else begin
            if (flush_q != 2'd2)
                flush_q <= flush_q + 2'd1;
            if (flush_q == 2'd2 && cs_n_p1)
                cs_arm_q <= 1'b1;
        end
    end

    assign cs_fall    = cs_arm_q & cs_n_p2 & ~cs_n_p1;
    assign busy       = ~cs_n_p1;
    assign lead_stb   = (sck_p1 != SCK_IDLE) && (sck_p2 == SCK_IDLE);
    assign trail_stb  = (sck_p1 == SCK_IDLE) && (sck_p2 != SCK_IDLE);
    assign active     = (state_q == SHIFT) && !cs_n_p1;
    assign sample_stb = active && ((PHASE == 0) ? lead_stb : trail_stb);
    assign shift_stb  = active && ((PHASE == 0) ? (trail_stb && bit_cnt != 3'd0) : lead_stb);
    assign tx_word    = tx_valid ? tx_data : 8'hFF;

    always_ff @(posedge clock) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load_en  = 1'b0;
        tx_ready = 1'b0;
        case (state_q)
            IDLE:    if (cs_fall) state_d = LOAD;
            LOAD: begin
                load_en = 1'b1;
                state_d = SHIFT;
            end
            SHIFT:   load_en = push_vld_p0;
            default: state_d = IDLE;
        endcase
        tx_ready = load_en && tx_valid;
        if (cs_n_p1)
            state_d = IDLE;
    end

    // Transmit: PHASE 0 presents the MSB at load time, PHASE 1 on the first shift strobe
    always_ff @(posedge clock) begin
        if (load_en)
            tx_sr <= (PHASE == 0) ? {tx_word[DATA_W-2:0], 1'b1} : tx_word;
        else if (shift_stb)
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b1};
    end

    always_ff @(posedge clock) begin
        if (!rst_n)
            miso_q <= 1'b0;
        else if (state_q == IDLE)
            miso_q <= 1'b0;
        else if (load_en) begin
            if (PHASE == 0)
                miso_q <= tx_word[DATA_W-1];
        end else if (shift_stb)
            miso_q <= tx_sr[DATA_W-1];
    end

    assign miso = (state_q != IDLE) && miso_q;

    // Receive: shift on sample strobes, push_vld_p0 marks the completed byte one clock later
    always_ff @(posedge clock) begin
        if (sample_stb)
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_p1};
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            bit_cnt     <= 3'd0;
            push_vld_p0 <= 1'b0;
            byte_cnt    <= 8'd0;
        end else begin
            push_vld_p0 <= sample_stb && (bit_cnt == 3'd7);
            if (!active)
                bit_cnt <= 3'd0;
            else if (sample_stb)
                bit_cnt <= bit_cnt + 3'd1;
            if (cs_fall)
                byte_cnt <= 8'd0;
            else if (push_vld_p0)
                byte_cnt <= sat_inc(byte_cnt);
        end
    end

    assign push   = push_vld_p0;
    assign pop    = rx_valid && rx_ready;
    assign accept = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (!rst_n)
            rx_ovr <= 1'b0;
        else if (push && full && !pop)
            rx_ovr <= 1'b1;
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
    logic [DATA_W-1:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;

    always_ff @(posedge clock) begin
        if (accept)
            mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({accept, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign full     = (count == 3'd4);
    assign rx_valid = (count != 3'd0);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
`else
    logic [DATA_W-1:0] hold_q;
    logic hold_vld;

    always_ff @(posedge clock) begin
        if (accept)
            hold_q <= rx_shift;
    end

    always_ff @(posedge clock) begin
        if (!rst_n)
            hold_vld <= 1'b0;
        else if (accept)
            hold_vld <= 1'b1;
        else if (pop)
            hold_vld <= 1'b0;
    end

    assign full     = hold_vld;
    assign rx_valid = hold_vld;
    assign rx_data  = hold_vld ? hold_q : 8'h00;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
`timescale 1ns/1ps
// Directed bench: u0 runs PHASE=0/ACTIVE=0, u1 runs PHASE=1/ACTIVE=1, each driven by a bit-banged master.
module tb_spi_slave_core;

    localparam int HALF = 31;

    logic clock = 1'b0;
    always #2 clock = ~clock;

    logic       rst_n;
    logic       cs0, sck0, mosi0, rx_ready0, tx_valid0;
    logic [7:0] tx_data0;
    logic       miso0, rx_valid0, tx_ready0, busy0, rx_ovr0;
    logic [7:0] rx_data0, byte_cnt0;
    logic       cs1, sck1, mosi1, rx_ready1, tx_valid1;
    logic [7:0] tx_data1;
    logic       miso1, rx_valid1, tx_ready1, busy1, rx_ovr1;
    logic [7:0] rx_data1, byte_cnt1;

    int vectors = 0;
    int miscompares = 0;
    int txr0 = 0;
    int txr1 = 0;
    int rxn1 = 0;
    logic [7:0] rxlog1 [8];
    logic [7:0] mi, mi2, junk;
    logic [7:0] mis [5];

    spi_slave_core #(.PHASE(0), .ACTIVE(0)) u0 (
        .clock(clock), .rst_n(rst_n), .cs_n(cs0), .sck(sck0), .mosi(mosi0), .miso(miso0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .busy(busy0), .rx_ovr(rx_ovr0), .byte_cnt(byte_cnt0)
    );

    spi_slave_core #(.PHASE(1), .ACTIVE(1)) u1 (
        .clock(clock), .rst_n(rst_n), .cs_n(cs1), .sck(sck1), .mosi(mosi1), .miso(miso1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .busy(busy1), .rx_ovr(rx_ovr1), .byte_cnt(byte_cnt1)
    );

    // Producer side: withdraw tx_valid once the byte has been taken.
    always @(negedge clock) begin
        if (tx_ready0) begin
            txr0++;
            @(posedge clock);
            #1 tx_valid0 = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (tx_ready1) begin
            txr1++;
            @(posedge clock);
            #1 tx_valid1 = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (rx_valid1 && rx_ready1) begin
            if (rxn1 < 8)
                rxlog1[rxn1] = rx_data1;
            rxn1++;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int u, input logic [7:0] mo, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (u == 0) begin
                mosi0 = mo[i];
                #HALF;
                sck0 = 1'b1;
                got[i] = miso0;
                #HALF;
                sck0 = 1'b0;
            end else begin
                sck1 = 1'b0;
                mosi1 = mo[i];
                #HALF;
                sck1 = 1'b1;
                got[i] = miso1;
                #HALF;
            end
        end
    endtask

    task automatic frame_start(input int u);
        if (u == 0) cs0 = 1'b0; else cs1 = 1'b0;
        #(2*HALF);
    endtask

    task automatic frame_end(input int u);
        #HALF;
        if (u == 0) cs0 = 1'b1; else cs1 = 1'b1;
        #(4*HALF);
        @(negedge clock);
    endtask

    task automatic pop0();
        rx_ready0 = 1'b1;
        @(negedge clock);
        rx_ready0 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cs0 = 1'b1; sck0 = 1'b0; mosi0 = 1'b0; rx_ready0 = 1'b0; tx_valid0 = 1'b0; tx_data0 = 8'h00;
        cs1 = 1'b1; sck1 = 1'b1; mosi1 = 1'b0; rx_ready1 = 1'b0; tx_valid1 = 1'b0; tx_data1 = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_miso", miso0, 0);
        check("rst_rx_valid", rx_valid0, 0);
        check("rst_rx_data", rx_data0, 8'h00);
        check("rst_busy", busy0, 0);
        check("rst_byte_cnt", byte_cnt0, 8'h00);
        check("rst_u1_miso", miso1, 0);
        check("rst_u1_busy", busy1, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clock);

        // Mode 0: A5 in, 3C out
        tx_data0 = 8'h3C; tx_valid0 = 1'b1;
        frame_start(0);
        check("busy_in_frame", busy0, 1);
        xfer(0, 8'hA5, 8, mi);
        frame_end(0);
        check("m0_miso_byte", mi, 8'h3C);
        check("m0_rx_data", rx_data0, 8'hA5);
        check("m0_rx_valid", rx_valid0, 1);
        check("m0_tx_ready_pulses", 8'(txr0), 8'd1);
        check("m0_byte_cnt", byte_cnt0, 8'd1);
        check("m0_busy_idle", busy0, 0);
        check("m0_miso_idle", miso0, 0);
        check("m0_no_ovr", rx_ovr0, 0);
        pop0();
        check("m0_popped", rx_valid0, 0);

        // Mode 1/idle-high: 01, 80 with nothing offered
        rx_ready1 = 1'b1;
        frame_start(1);
        xfer(1, 8'h01, 8, mi);
        xfer(1, 8'h80, 8, mi2);
        frame_end(1);
        check("m1_rx_count", 8'(rxn1), 8'd2);
        check("m1_rx0", rxlog1[0], 8'h01);
        check("m1_rx1", rxlog1[1], 8'h80);
        check("m1_miso0", mi, 8'hFF);
        check("m1_miso1", mi2, 8'hFF);
        check("m1_byte_cnt", byte_cnt1, 8'd2);
        check("m1_no_tx_ready", 8'(txr1), 8'd0);

        // Mode 1 with a real tx byte followed by filler
        tx_data1 = 8'h96; tx_valid1 = 1'b1;
        frame_start(1);
        xfer(1, 8'h3B, 8, mi);
        xfer(1, 8'h6C, 8, mi2);
        frame_end(1);
        check("m1b_rx0", rxlog1[2], 8'h3B);
        check("m1b_rx1", rxlog1[3], 8'h6C);
        check("m1b_miso0", mi, 8'h96);
        check("m1b_miso1", mi2, 8'hFF);
        check("m1b_tx_ready_pulses", 8'(txr1), 8'd1);

        // Aborted byte after 5 bits, then a clean frame
        frame_start(0);
        xfer(0, 8'hE7, 5, junk);
        frame_end(0);
        check("abort_rx_valid", rx_valid0, 0);
        check("abort_byte_cnt", byte_cnt0, 8'd0);
        frame_start(0);
        xfer(0, 8'h5A, 8, mi);
        frame_end(0);
        check("after_abort_rx", rx_data0, 8'h5A);
        check("after_abort_valid", rx_valid0, 1);
        check("after_abort_cnt", byte_cnt0, 8'd1);
        check("after_abort_miso", mi, 8'hFF);
        pop0();

        // Five bytes with nobody draining the buffer
        tx_data0 = 8'h81; tx_valid0 = 1'b1;
        frame_start(0);
        for (int k = 0; k < 5; k++)
            xfer(0, 8'(8'h10 + k), 8, mis[k]);
        frame_end(0);
        check("ovr_flag", rx_ovr0, 1);
        check("ovr_byte_cnt", byte_cnt0, 8'd5);
        check("ovr_miso0", mis[0], 8'h81);
        check("ovr_miso1", mis[1], 8'hFF);
        check("ovr_tx_ready_pulses", 8'(txr0), 8'd2);
`ifdef SPI_SLAVE_RX_FIFO_EN
        for (int k = 0; k < 4; k++) begin
            check("fifo_head", rx_data0, 8'(8'h10 + k));
            pop0();
        end
`else
        check("hold_head", rx_data0, 8'h10);
        pop0();
`endif
        check("drained", rx_valid0, 0);
        check("ovr_sticky", rx_ovr0, 1);

        // Reset pulse mid-byte
        frame_start(0);
        xfer(0, 8'hF0, 4, junk);
        @(negedge clock);
        rst_n = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        check("mid_rst_miso", miso0, 0);
        check("mid_rst_rx_valid", rx_valid0, 0);
        check("mid_rst_ovr", rx_ovr0, 0);
        check("mid_rst_byte_cnt", byte_cnt0, 8'd0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_rx_data", rx_data0, 8'h00);
        check("mid_rst_tx_ready", tx_ready0, 0);
        xfer(0, 8'hF0, 8, junk);
        xfer(0, 8'h0F, 8, junk);
        #(4*HALF);
        @(negedge clock);
        check("ignored_rx_valid", rx_valid0, 0);
        check("ignored_byte_cnt", byte_cnt0, 8'd0);
        check("ignored_miso", miso0, 0);
        frame_end(0);
        frame_start(0);
        xfer(0, 8'hC3, 8, mi);
        frame_end(0);
        check("post_rst_rx", rx_data0, 8'hC3);
        check("post_rst_valid", rx_valid0, 1);
        check("post_rst_cnt", byte_cnt0, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
